// File: rtl/divider_32bits_seq.sv
// Multi-cycle unsigned restoring divider.
// One quotient bit is resolved per clock through shift-subtract. Start/done
// handshake: start is honoured only in IDLE, done is a one-cycle pulse, and
// the quotient/remainder outputs hold their values until the next accepted start.
// Divide-by-zero skips the iteration. It reports all-ones / dividend with
// div_by_zero set.
module divider_32bits_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;          // working quotient / shifted dividend
  logic [WIDTH-1:0] r_reg, r_next;          // partial remainder
  logic [WIDTH-1:0] d_reg, d_next;          // captured divisor
  logic [CW-1:0]    cnt_reg, cnt_next;      // step counter, 0 .. WIDTH-1
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // One restoring step: shift the next dividend bit into R, then try to subtract D.
  logic [WIDTH-1:0] rs;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] step_q, step_r;

  // Datapath for a single restoring iteration.
  always_comb begin
    rs = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    t  = {1'b0, rs} - {1'b0, d_reg};
    if (!t[WIDTH]) begin
      step_r = t[WIDTH-1:0];
      step_q = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      step_r = rs;
      step_q = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          busy_next = 1'b1;
          if (divisor == '0) begin
            // No iteration needed; the result is defined directly.
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            done_next      = 1'b1;
            state_next     = DONE;
          end else begin
            // Outputs keep the previous result until this division finishes.
            q_next     = dividend;
            r_next     = '0;
            d_next     = divisor;
            cnt_next   = '0;
            dbz_next   = 1'b0;
            state_next = DIV;
          end
        end
      end

      DIV: begin
        q_next   = step_q;
        r_next   = step_r;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          quotient_next  = step_q;
          remainder_next = step_r;
          done_next      = 1'b1;
          state_next     = DONE;
        end
      end

      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any division in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_32bits_seq.sv
// Self-checking bench for divider_32bits_seq: table-driven vectors, a result
// scoreboard queue, and hand-written sequences for ignored start and reset abort.
module tb_divider_32bits_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  divider_32bits_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } exp_t;

  exp_t             sb[$];
  vec_t             vecs[6];
  int               n_pass  = 0;
  int               n_total = 0;
  logic [WIDTH-1:0] last_q  = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  // Launch one division, optionally injecting an ignored start at edge k+10,
  // then wait (bounded) for done and compare against the scoreboard.
  task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input logic ez, input bit inject);
    int   cycles;
    int   busy_cnt;
    int   exp_lat;
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back('{q: eq, r: er, z: ez});
    @(negedge clk);                       // edge k has passed
    start = 1'b0;
    if (b != '0) check("hold_q_on_accept", quotient, last_q);
    cycles   = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 200) begin
      if (inject && cycles == 10) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end
    start   = 1'b0;
    exp_lat = (b == '0) ? 1 : WIDTH + 1;
    check("done_seen", done, 1'b1);
    check("latency", cycles, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", div_by_zero, e.z);
      if (b != '0) begin
        check("invariant_sum", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
        check("invariant_rem_lt", remainder < b, 1'b1);
      end
      last_q = e.q;
    end
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_drop", busy, 1'b0);
    $display("div %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, cycles);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int               saw_done;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,    z: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,    z: 1'b0};
    vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   q: 32'd1,          r: 32'd0,    z: 1'b0};
    vecs[3] = '{a: 32'd5,          b: 32'd10,         q: 32'd0,          r: 32'd5,    z: 1'b0};
    vecs[4] = '{a: 32'd0,          b: 32'd3,          q: 32'd0,          r: 32'd0,    z: 1'b0};
    vecs[5] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd1234, z: 1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b0);

    // Start pulsed during DIV must be ignored; the queued op then runs normally.
    do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    do_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

    // Reset at edge k+15 abandons the division with no done pulse.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);          // edges k+1 .. k+14 passed
    rst_n = 1'b0;
    @(negedge clk);                      // edge k+15 applies reset
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", div_by_zero, 1'b0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    $display("abort at k+15 -> busy=%0d done=%0d q=%0d r=%0d", busy, done, quotient, remainder);
    last_q = '0;
    do_div(32'd50, 32'd8, 32'd6, 32'd2, 1'b0, 1'b0);

    // Random sweep; reference results come from the bench's own arithmetic.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) do_div(ra, rb, '1, ra, 1'b1, 1'b0);
      else          do_div(ra, rb, ra / rb, ra % rb, 1'b0, 1'b0);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
